// File: rtl/adc_sample_ctrl.sv
// ADC capture frame sequencer: paces samples with a rate divider, selects the
// channel or test-ramp data and writes tagged words into the USB upload FIFO.
module adc_sample_ctrl #(
   parameter int ADC_W = 14,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_sample,
   input  logic             abort,
   input  logic [1:0]       adc_ch_sel,
   input  logic [31:0]      set_sample_num,
   input  logic [31:0]      set_sample_speed,
   input  logic [ADC_W-1:0] adc_data_a,
   input  logic [ADC_W-1:0] adc_data_b,
   input  logic             fifo_full,
   output logic             fifo_wr_en,
   output logic [OUT_W-1:0] fifo_wr_data,
   output logic             busy,
   output logic             frame_done,
   output logic             overflow,
   output logic [31:0]      sample_cnt
);

   typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

   state_t           state_q;
   logic [1:0]       ch_q;
   logic [31:0]      num_q;
   logic [31:0]      speed_q;
   logic [31:0]      div_q;
   logic [31:0]      cnt_q;
   logic             alt_q;
   logic             wr_en_q;
   logic [OUT_W-1:0] wr_data_q;
   logic             busy_q;
   logic             done_q;
   logic             ovf_q;

   logic             tick;
   logic [31:0]      cnt_d;
   logic [OUT_W-1:0] word_d;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      tick   = (state_q == RUN) && (div_q == 32'd0);
      cnt_d  = cnt_q + 32'd1;
      word_d = '0;
      case (ch_q)
         2'b00: begin
            word_d[OUT_W-1 -: 2] = 2'b00;
            word_d[ADC_W-1:0]    = cnt_q[ADC_W-1:0];
         end
         2'b01: begin
            word_d[OUT_W-1 -: 2] = 2'b01;
            word_d[ADC_W-1:0]    = adc_data_a;
         end
         2'b10: begin
            word_d[OUT_W-1 -: 2] = 2'b10;
            word_d[ADC_W-1:0]    = adc_data_b;
         end
         default: begin
            // Alternate mode: alt_q=0 selects A, flips on each written sample.
            word_d[OUT_W-1 -: 2] = alt_q ? 2'b10 : 2'b01;
            word_d[ADC_W-1:0]    = alt_q ? adc_data_b : adc_data_a;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ch_q      <= 2'b00;
         num_q     <= 32'd0;
         speed_q   <= 32'd0;
         div_q     <= 32'd0;
         cnt_q     <= 32'd0;
         alt_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_sample) begin
                  ch_q    <= adc_ch_sel;
                  num_q   <= set_sample_num;
                  speed_q <= set_sample_speed;
                  ovf_q   <= 1'b0;
                  cnt_q   <= 32'd0;
                  alt_q   <= 1'b0;
                  if (set_sample_num == 32'd0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ARM;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ARM: begin
               div_q <= 32'd0;
               if (abort) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  div_q <= tick ? speed_q : div_q - 32'd1;
                  if (tick) begin
                     if (fifo_full) begin
                        ovf_q <= 1'b1;
                     end else begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= word_d;
                        cnt_q     <= cnt_d;
                        alt_q     <= ~alt_q;
                        if (cnt_d == num_q) begin
                           state_q <= DONE;
                           done_q  <= 1'b1;
                           busy_q  <= 1'b0;
                        end
                     end
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fifo_wr_en   = wr_en_q;
   assign fifo_wr_data = wr_data_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign overflow     = ovf_q;
   assign sample_cnt   = cnt_q;

endmodule
